// File: rtl/systolic_west_feeder.sv
// -----------------------------------------------------------------------------
// systolic_west_feeder
//
// West-edge driver for a systolic PE array. It takes one row-aligned vector per
// beat and skews it so that row r sees its element r cycles after row 0. It
// drives each row's input/valid/switch wires into column 0. Before the first
// beat of a new weight tile, it injects a switch pulse that promotes the shadow
// weights. That pulse reaches every PE exactly one cycle ahead of the tile's
// first valid data.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid_i        upstream beat valid
//   in_ready_o        upstream beat accepted when in_valid_i && in_ready_o
//   in_data_i         element r at [r*DATA_W +: DATA_W]
//   in_tile_start_i   beat is first vector of a new weight tile
//   in_last_i         beat is last vector of the job
//   weights_ready_i   shadow weights fully loaded in all PEs
//   sw_ack_o          1-cycle pulse while the switch is being injected
//   out_input_o       per-row PE data input
//   out_valid_o       per-row PE valid input
//   out_switch_o      per-row PE switch input
//   busy_o            FSM active or anything still in the skew pipeline
//   done_o            1-cycle pulse: last beat's row ROWS-1 element on outputs
// -----------------------------------------------------------------------------
module systolic_west_feeder #(
   parameter int unsigned ROWS   = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [ROWS*DATA_W-1:0] in_data_i,
   input  logic                   in_tile_start_i,
   input  logic                   in_last_i,
   input  logic                   weights_ready_i,
   output logic                   sw_ack_o,
   output logic [ROWS*DATA_W-1:0] out_input_o,
   output logic [ROWS-1:0]        out_valid_o,
   output logic [ROWS-1:0]        out_switch_o,
   output logic                   busy_o,
   output logic                   done_o
);

   typedef enum logic [2:0] {
      StIdle,
      StStream,
      StSwWait,
      StSwitch,
      StDrain
   } state_e;

   state_e          state_q;
   logic            sw_issued_q;
   logic            sw_ack_q;
   logic [ROWS-1:0] valid_q;   // bit k = valid at skew stage k (stage k drives row k)
   logic [ROWS-1:0] switch_q;
   logic [ROWS-1:0] last_q;

   logic can_take;
   logic need_switch;
   logic accept;

   assign can_take    = (state_q == StIdle) || (state_q == StStream);
   // A tile_start beat is held back until its switch has been injected.
   assign in_ready_o  = can_take && (!in_tile_start_i || sw_issued_q);
   assign accept      = in_valid_i && in_ready_o;
   assign need_switch = in_valid_i && in_tile_start_i && !sw_issued_q;

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         sw_issued_q <= 1'b0;
         sw_ack_q    <= 1'b0;
      end else begin
         sw_ack_q <= 1'b0;
         if (accept) begin
            sw_issued_q <= 1'b0;
         end
         unique case (state_q)
            StIdle, StStream: begin
               if (need_switch) begin
                  if (weights_ready_i) begin
                     state_q  <= StSwitch;
                     sw_ack_q <= 1'b1;
                  end else begin
                     state_q <= StSwWait;
                  end
               end else if (accept) begin
                  state_q <= in_last_i ? StDrain : StStream;
               end
            end
            StSwWait: begin
               // Upstream withdrew the held beat: abandon the switch.
               if (!in_valid_i) begin
                  state_q <= StStream;
               end else if (weights_ready_i) begin
                  state_q  <= StSwitch;
                  sw_ack_q <= 1'b1;
               end
            end
            StSwitch: begin
               state_q     <= StStream;
               sw_issued_q <= 1'b1;
            end
            StDrain: begin
               if (done_o) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Skew pipeline for the control bits. It never stalls; idle cycles shift in
   // zeros.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= '0;
         switch_q <= '0;
         last_q   <= '0;
      end else begin
         valid_q  <= {valid_q[ROWS-2:0], accept};
         switch_q <= {switch_q[ROWS-2:0], state_q == StSwitch};
         last_q   <= {last_q[ROWS-2:0], accept && in_last_i};
      end
   end

   // Each row only needs its own element, so row r gets an (r+1)-deep delay
   // line instead of carrying the whole vector through every stage.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_W-1:0] pipe_q [r+1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k <= r; k++) begin
               pipe_q[k] <= '0;
            end
         end else begin
            pipe_q[0] <= accept ? in_data_i[r*DATA_W +: DATA_W] : '0;
            for (int k = 1; k <= r; k++) begin
               pipe_q[k] <= pipe_q[k-1];
            end
         end
      end

      assign out_input_o[r*DATA_W +: DATA_W] = pipe_q[r];
   end

   assign out_valid_o  = valid_q;
   assign out_switch_o = switch_q;
   assign sw_ack_o     = sw_ack_q;
   assign done_o       = last_q[ROWS-1];
   assign busy_o       = (state_q != StIdle) || (|valid_q) || (|switch_q);

endmodule

// File: tb/tb_systolic_west_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_west_feeder
//
// Directed bench for systolic_west_feeder with ROWS=4, DATA_W=8. Inputs change
// 1 time unit after the rising edge. Outputs are checked at that same point,
// before any input changes.
// -----------------------------------------------------------------------------
module tb_systolic_west_feeder;

   localparam int unsigned ROWS   = 4;
   localparam int unsigned DATA_W = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [ROWS*DATA_W-1:0] in_data;
   logic                   in_tile_start;
   logic                   in_last;
   logic                   weights_ready;
   logic                   sw_ack;
   logic [ROWS*DATA_W-1:0] out_input;
   logic [ROWS-1:0]        out_valid;
   logic [ROWS-1:0]        out_switch;
   logic                   busy;
   logic                   done;

   int n_tests = 0;
   int n_fail  = 0;

   systolic_west_feeder #(
      .ROWS   (ROWS),
      .DATA_W (DATA_W)
   ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid_i      (in_valid),
      .in_ready_o      (in_ready),
      .in_data_i       (in_data),
      .in_tile_start_i (in_tile_start),
      .in_last_i       (in_last),
      .weights_ready_i (weights_ready),
      .sw_ack_o        (sw_ack),
      .out_input_o     (out_input),
      .out_valid_o     (out_valid),
      .out_switch_o    (out_switch),
      .busy_o          (busy),
      .done_o          (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rows(input string tag, input logic [3:0] ev, input logic [31:0] ed,
                           input logic [3:0] es);
      chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, "_data"}, out_input, ed);
      chk({tag, "_switch"}, 32'(out_switch), 32'(es));
   endtask

   // Row 0 element first.
   function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
      return {d, c, b, a};
   endfunction

   logic [3:0]  ev;
   logic [3:0]  es;
   logic [31:0] ed;
   int          ack_cnt;

   initial begin
      rst           = 1'b1;
      in_valid      = 1'b0;
      in_data       = '0;
      in_tile_start = 1'b0;
      in_last       = 1'b0;
      weights_ready = 1'b0;

      // ---- reset state ----
      tick();
      tick();
      chk_rows("rst", 4'b0, 32'h0, 4'b0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_ack", 32'(sw_ack), 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_ready", 32'(in_ready), 32'h1);

      // ---- three beats, no tile_start: skewed output ----
      in_valid = 1'b1;
      in_data  = pk(1, 2, 3, 4);
      for (int k = 1; k <= 6; k++) begin
         tick();
         case (k)
            1: in_data = pk(5, 6, 7, 8);
            2: in_data = pk(9, 10, 11, 12);
            3: begin in_valid = 1'b0; in_data = '0; end
            default: ;
         endcase
         ev = '0;
         ed = '0;
         for (int r = 0; r < 4; r++) begin
            int b;
            b = k - 1 - r;
            if (b >= 0 && b <= 2) begin
               ev[r]        = 1'b1;
               ed[r*8 +: 8] = 8'(4 * b + r + 1);
            end
         end
         chk_rows($sformatf("t2_c%0d", k), ev, ed, 4'b0);
      end

      // ---- tile_start with weights ready: switch one cycle ahead of data ----
      ack_cnt       = 0;
      in_valid      = 1'b1;
      in_tile_start = 1'b1;
      in_data       = pk(7, 7, 7, 7);
      weights_ready = 1'b1;
      #1;
      chk("t3_ready_held", 32'(in_ready), 32'h0);
      tick();
      ack_cnt += int'(sw_ack);
      chk("t3_sw_ack", 32'(sw_ack), 32'h1);
      chk("t3_ready_switch", 32'(in_ready), 32'h0);
      tick();
      ack_cnt += int'(sw_ack);
      chk("t3_ready_after", 32'(in_ready), 32'h1);
      for (int k = 0; k <= 4; k++) begin
         ev = '0;
         es = '0;
         ed = '0;
         for (int r = 0; r < 4; r++) begin
            es[r] = (k == r);
            if (k == r + 1) begin
               ev[r]        = 1'b1;
               ed[r*8 +: 8] = 8'd7;
            end
         end
         chk_rows($sformatf("t3_c%0d", k), ev, ed, es);
         tick();
         ack_cnt += int'(sw_ack);
         if (k == 0) begin
            in_valid      = 1'b0;
            in_tile_start = 1'b0;
            in_data       = '0;
         end
      end
      chk("t3_ack_once", 32'(ack_cnt), 32'h1);

      // ---- tile_start while weights not ready: bubbles, then switch ----
      in_valid      = 1'b1;
      in_tile_start = 1'b1;
      in_data       = pk(3, 3, 3, 3);
      weights_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4_ready_w%0d", i), 32'(in_ready), 32'h0);
         chk($sformatf("t4_ack_w%0d", i), 32'(sw_ack), 32'h0);
         chk_rows($sformatf("t4_w%0d", i), 4'b0, 32'h0, 4'b0);
         if (i == 4) begin
            weights_ready = 1'b1;
         end
         tick();
      end
      chk("t4_sw_ack", 32'(sw_ack), 32'h1);
      chk("t4_ready_switch", 32'(in_ready), 32'h0);
      tick();
      chk("t4_ready_after", 32'(in_ready), 32'h1);
      chk_rows("t4_sw0", 4'b0, 32'h0, 4'b0001);
      tick();
      chk_rows("t4_data0", 4'b0001, pk(3, 0, 0, 0), 4'b0010);
      in_valid      = 1'b0;
      in_tile_start = 1'b0;
      in_data       = '0;
      weights_ready = 1'b0;
      repeat (4) tick();

      // ---- single beat with tile_start + last: switch, skew, done, idle ----
      in_valid      = 1'b1;
      in_tile_start = 1'b1;
      in_last       = 1'b1;
      in_data       = pk(8'h80, 8'h7f, 8'hff, 8'h00);
      weights_ready = 1'b1;
      tick();
      chk("t5_sw_ack", 32'(sw_ack), 32'h1);
      tick();
      chk("t5_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid      = 1'b0;
      in_tile_start = 1'b0;
      in_last       = 1'b0;
      in_data       = '0;
      weights_ready = 1'b0;
      chk("t5_ready_drain", 32'(in_ready), 32'h0);
      for (int k = 1; k <= 4; k++) begin
         logic [31:0] beat;
         beat = pk(8'h80, 8'h7f, 8'hff, 8'h00);
         ev = '0;
         es = '0;
         ed = '0;
         for (int r = 0; r < 4; r++) begin
            es[r] = (k == r);
            if (k == r + 1) begin
               ev[r]        = 1'b1;
               ed[r*8 +: 8] = beat[r*8 +: 8];
            end
         end
         chk_rows($sformatf("t5_c%0d", k), ev, ed, es);
         chk($sformatf("t5_done_c%0d", k), 32'(done), 32'(k == 4));
         chk($sformatf("t5_busy_c%0d", k), 32'(busy), 32'h1);
         tick();
      end
      chk("t5_busy_end", 32'(busy), 32'h0);
      chk("t5_done_end", 32'(done), 32'h0);
      chk("t5_ready_idle", 32'(in_ready), 32'h1);

      // ---- two-cycle gap in in_valid mid-stream ----
      in_valid = 1'b1;
      in_data  = pk(10, 11, 12, 13);
      for (int k = 1; k <= 7; k++) begin
         tick();
         case (k)
            1: begin in_valid = 1'b0; in_data = '0; end
            3: begin in_valid = 1'b1; in_data = pk(20, 21, 22, 23); end
            4: begin in_valid = 1'b0; in_data = '0; end
            default: ;
         endcase
         ev = '0;
         ed = '0;
         for (int r = 0; r < 4; r++) begin
            if (k - 1 - r == 0) begin
               ev[r]        = 1'b1;
               ed[r*8 +: 8] = 8'(10 + r);
            end else if (k - 1 - r == 3) begin
               ev[r]        = 1'b1;
               ed[r*8 +: 8] = 8'(20 + r);
            end
         end
         chk_rows($sformatf("t6_c%0d", k), ev, ed, 4'b0);
      end

      // ---- reset in the middle of a stream ----
      in_valid = 1'b1;
      in_data  = pk(5, 5, 5, 5);
      tick();
      tick();
      chk("t1_busy_pre", 32'(busy), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk_rows("t1_rst", 4'b0, 32'h0, 4'b0);
      chk("t1_busy", 32'(busy), 32'h0);
      chk("t1_done", 32'(done), 32'h0);
      in_valid = 1'b0;
      in_data  = '0;
      tick();
      rst = 1'b0;
      #1;
      chk("t1_ready", 32'(in_ready), 32'h1);
      tick();
      chk_rows("t1_after", 4'b0, 32'h0, 4'b0);
      chk("t1_busy_after", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
